// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: FSM state encodings, field widths
// and the latched load/store payload layout.
package mem_arbiter_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned FUNCT3_W = 3;

    localparam logic [2:0] ARB_IDLE     = 3'd0;
    localparam logic [2:0] ARB_ISSUE_F  = 3'd1;
    localparam logic [2:0] ARB_WAIT_F   = 3'd2;
    localparam logic [2:0] ARB_ISSUE_LS = 3'd3;
    localparam logic [2:0] ARB_WAIT_LS  = 3'd4;
    localparam logic [2:0] ARB_DRAIN    = 3'd5;

    // Load/store operation held on the memctrl io_* inputs for a whole access
    typedef struct packed {
        logic                store;
        logic [XLEN-1:0]     addr;
        logic [XLEN-1:0]     data;
        logic [FUNCT3_W-1:0] op;
    } ls_payload_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memctrl port between instruction fetch and
// the load/store buffer. LSB has priority, bounded by a starvation counter
// that forces a fetch grant after STARVE_LIMIT back-to-back LS grants.
// A pipeline clear drops a fetch that has not been accepted and drains one
// that has; load/store accesses always run to completion.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable), clear (flush)
//   ic_*  : fetch request/address in, done/instruction out
//   ls_*  : load/store request/payload in, done/load data out
//   mc_*  : registered request to memctrl, working/back/result from memctrl
//   busy  : arbiter not idle
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic [31:0] ic_data,
    input  logic        ls_req,
    input  logic        ls_store,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_data,
    input  logic [2:0]  ls_op,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        mc_is_fetch,
    output logic [31:0] mc_fetch_addr,
    output logic        mc_is_io,
    output logic        mc_is_store,
    output logic [31:0] mc_io_addr,
    output logic [31:0] mc_io_data,
    output logic [2:0]  mc_io_op,
    input  logic        mc_working,
    input  logic        mc_is_back,
    input  logic [31:0] mc_back_ins,
    input  logic        mc_res_avail,
    input  logic [31:0] mc_res,
    output logic        busy
);

    logic [STATE_W-1:0] state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               fetch_en, fetch_en_nx;
    logic [XLEN-1:0]    fetch_addr, fetch_addr_nx;
    logic               io_en, io_en_nx;
    ls_payload_t        pl, pl_nx;

    // Next-state and next-register values
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        fetch_en_nx   = fetch_en;
        fetch_addr_nx = fetch_addr;
        io_en_nx      = io_en;
        pl_nx         = pl;
        case (state)
            ARB_IDLE: begin
                if (ls_req && (!ic_req || (cnt < CNT_W'(STARVE_LIMIT)))) begin
                    pl_nx    = '{store: ls_store, addr: ls_addr, data: ls_data, op: ls_op};
                    io_en_nx = 1'b1;
                    state_nx = ARB_ISSUE_LS;
                    // Only LS grants that overtake a waiting fetch count
                    cnt_nx   = ic_req ? cnt + CNT_W'(1) : '0;
                end else if (ic_req && !clear) begin
                    fetch_addr_nx = ic_addr;
                    fetch_en_nx   = 1'b1;
                    state_nx      = ARB_ISSUE_F;
                    cnt_nx        = '0;
                end
            end
            ARB_ISSUE_F: begin
                if (mc_working) begin
                    fetch_en_nx = 1'b0;
                    state_nx    = clear ? ARB_DRAIN : ARB_WAIT_F;
                end else if (clear) begin
                    fetch_en_nx = 1'b0;
                    state_nx    = ARB_IDLE;
                end
            end
            ARB_WAIT_F: begin
                // A return coinciding with clear is simply discarded
                if (clear) begin
                    state_nx = mc_is_back ? ARB_IDLE : ARB_DRAIN;
                end else if (mc_is_back) begin
                    state_nx = ARB_IDLE;
                end
            end
            ARB_DRAIN: begin
                if (mc_is_back) begin
                    state_nx = ARB_IDLE;
                end
            end
            ARB_ISSUE_LS: begin
                // Payload stays driven: memctrl reads io_data/io_op throughout
                if (mc_working) begin
                    io_en_nx = 1'b0;
                    state_nx = ARB_WAIT_LS;
                end
            end
            ARB_WAIT_LS: begin
                if (mc_res_avail) begin
                    state_nx = ARB_IDLE;
                end
            end
            default: begin
                state_nx    = ARB_IDLE;
                fetch_en_nx = 1'b0;
                io_en_nx    = 1'b0;
            end
        endcase
    end

    // State and payload registers; rdy_in low freezes everything
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= ARB_IDLE;
            cnt        <= '0;
            fetch_en   <= 1'b0;
            fetch_addr <= '0;
            io_en      <= 1'b0;
            pl         <= '0;
        end else if (rdy_in) begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            fetch_en   <= fetch_en_nx;
            fetch_addr <= fetch_addr_nx;
            io_en      <= io_en_nx;
            pl         <= pl_nx;
        end
    end

    // Completions are same-cycle with memctrl and gated to the owning state
    always_comb begin
        ic_done  = !rst_in && rdy_in && (state == ARB_WAIT_F) && mc_is_back && !clear;
        ls_done  = !rst_in && rdy_in && (state == ARB_WAIT_LS) && mc_res_avail;
        ic_data  = ic_done ? mc_back_ins : '0;
        ls_rdata = ls_done ? mc_res : '0;
    end

    assign mc_is_fetch   = fetch_en;
    assign mc_fetch_addr = fetch_addr;
    assign mc_is_io      = io_en;
    assign mc_is_store   = pl.store;
    assign mc_io_addr    = pl.addr;
    assign mc_io_data    = pl.data;
    assign mc_io_op      = pl.op;
    assign busy          = (state != ARB_IDLE);

endmodule
